// File: rtl/track_sequencer.sv
// Track sequencer: selects one of 16 tracks, walks its notes from an external ROM and times each note.
// Optional AUTO_ADVANCE_EN: at end of a non-looping track, advance to the next track and keep playing.
module track_sequencer #(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int GAP_TICKS      = 1_250_000,
  parameter int NOTE_ADDR_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_play,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     loop_en,
  output logic [NOTE_ADDR_W+3:0]   rom_addr,
  input  logic [11:0]              rom_data,
  output logic [3:0]               current_track,
  output logic                     playing,
  output logic [7:0]               note_out,
  output logic                     note_valid,
  output logic                     track_done
);

  localparam int CW = $clog2(15 * TICKS_PER_UNIT + 1);
  localparam logic [CW-1:0] TPU_C = CW'(TICKS_PER_UNIT);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_TICKS);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [NOTE_ADDR_W-1:0] IDX_ONE = NOTE_ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, PAUSED} state_t;

  state_t                  state_reg, state_next;
  state_t                  resume_reg, resume_next;
  logic [CW-1:0]           counter_reg, counter_next;
  logic [NOTE_ADDR_W-1:0]  note_idx_reg, note_idx_next;
  logic [3:0]              track_reg, track_next;
  logic [7:0]              note_reg, note_next;
  logic                    track_done_reg, track_done_next;
  logic                    play_d, next_d, prev_d;

  logic play_edge, next_edge, prev_edge, track_change, active, end_of_track;

  assign play_edge    = btn_play & ~play_d;
  assign next_edge    = btn_next & ~next_d;
  assign prev_edge    = btn_prev & ~prev_d;
  assign track_change = next_edge ^ prev_edge;
  assign active       = (state_reg == FETCH) || (state_reg == WAIT) ||
                        (state_reg == PLAY)  || (state_reg == GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      resume_reg     <= IDLE;
      counter_reg    <= '0;
      note_idx_reg   <= '0;
      track_reg      <= '0;
      note_reg       <= '0;
      track_done_reg <= 1'b0;
      play_d         <= 1'b0;
      next_d         <= 1'b0;
      prev_d         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resume_reg     <= resume_next;
      counter_reg    <= counter_next;
      note_idx_reg   <= note_idx_next;
      track_reg      <= track_next;
      note_reg       <= note_next;
      track_done_reg <= track_done_next;
      play_d         <= btn_play;
      next_d         <= btn_next;
      prev_d         <= btn_prev;
    end
  end

  always_comb begin
    state_next      = state_reg;
    resume_next     = resume_reg;
    counter_next    = counter_reg;
    note_idx_next   = note_idx_reg;
    track_next      = track_reg;
    note_next       = note_reg;
    track_done_next = 1'b0;
    end_of_track    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (play_edge) begin
          state_next    = FETCH;
          note_idx_next = '0;
        end
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        // rom_data reflects the address presented during FETCH
        if (rom_data[11:8] == 4'd0) begin
          end_of_track = 1'b1;
        end else begin
          note_next    = rom_data[7:0];
          counter_next = CW'(rom_data[11:8]) * TPU_C - GAP_C;
          state_next   = PLAY;
        end
      end
      PLAY: begin
        if (counter_reg == ONE_C) begin
          state_next   = GAP;
          counter_next = GAP_C;
        end else begin
          counter_next = counter_reg - ONE_C;
        end
      end
      GAP: begin
        if (counter_reg == ONE_C) begin
          if (note_idx_reg == '1) begin
            end_of_track = 1'b1;
          end else begin
            note_idx_next = note_idx_reg + IDX_ONE;
            state_next    = FETCH;
          end
        end else begin
          counter_next = counter_reg - ONE_C;
        end
      end
      PAUSED: begin
        if (play_edge) state_next = resume_reg;
      end
      default: state_next = IDLE;
    endcase

    if (end_of_track) begin
      track_done_next = 1'b1;
      note_idx_next   = '0;
      if (loop_en) begin
        state_next = FETCH;
      end else begin
`ifdef AUTO_ADVANCE_EN
        track_next = track_reg + 4'd1;
        state_next = FETCH;
`else
        state_next = IDLE;
`endif
      end
    end

    // Pausing lets this cycle's step complete and freezes the step it produced.
    if (play_edge && active && (state_next != IDLE)) begin
      resume_next = state_next;
      state_next  = PAUSED;
    end

    if (track_change) begin
      track_next      = next_edge ? track_reg + 4'd1 : track_reg - 4'd1;
      note_idx_next   = '0;
      track_done_next = 1'b0;
      resume_next     = resume_reg;
      state_next      = active ? FETCH : IDLE;
    end
  end

  assign rom_addr      = {track_reg, note_idx_reg};
  assign current_track = track_reg;
  assign playing       = active;
  assign note_valid    = (state_reg == PLAY) && (note_reg != 8'd0);
  assign note_out      = (state_reg == PLAY) ? note_reg : 8'd0;
  assign track_done    = track_done_reg;

endmodule
